psram_arbiter: RTL and testbench

- Two-requester round-robin controller in front of the `psram` top.
- Owns the psram-side `read_sw`/`write_sw`/`address`/`data_in` inputs. Sequences one QPI read or write at a time.
- Waits for `endcommand`, returns read data, and enforces an inter-transaction CE-high gap and a watchdog timeout.
- Sits between user logic (e.g. a capture engine and a UART dump path) and `psram`, in the `mem_clk` domain.

---
 rtl/psram_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 23 ++
 rtl/psram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_psram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared state encoding and requester ids for the PSRAM arbiter
package psram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        RELEASE,
        GAP
    } arb_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import psram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last,
    output logic gnt_id,
    output logic valid
);

    // On contention the requester that was not served last wins.
    always_comb begin
        valid  = a_req | b_req;
        gnt_id = REQ_A;
        if (a_req && b_req) begin
            gnt_id = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (b_req) begin
            gnt_id = REQ_B;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-requester round-robin sequencer in front of the psram controller
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              qpi_on,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,

    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              read_sw,
    output logic              write_sw,
    input  logic              endcommand,
    input  logic [DATA_W-1:0] data_out
);

    localparam int CNT_W = $clog2(TIMEOUT + HOLD_CYCLES + GAP_CYCLES + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             last_id;
    logic             win_id;
    logic             win_we;
    logic             pick_id;
    logic             pick_valid;
    logic             grant;

    rr_arb2 u_rr (
        .a_req  (a_req),
        .b_req  (b_req),
        .last   (last_id),
        .gnt_id (pick_id),
        .valid  (pick_valid)
    );

    // Grant is decided and acknowledged in the IDLE cycle itself.
    assign grant = (state == IDLE) && qpi_on && pick_valid;
    assign a_gnt = grant && (pick_id == REQ_A);
    assign b_gnt = grant && (pick_id == REQ_B);
    assign busy  = (state != IDLE);

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_id  <= REQ_B;
            win_id   <= REQ_A;
            win_we   <= 1'b0;
            address  <= '0;
            data_in  <= '0;
            read_sw  <= 1'b0;
            write_sw <= 1'b0;
            a_done   <= 1'b0;
            a_err    <= 1'b0;
            a_rdata  <= '0;
            b_done   <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_done <= 1'b0;
            a_err  <= 1'b0;
            b_done <= 1'b0;
            b_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        win_id   <= pick_id;
                        win_we   <= (pick_id == REQ_B) ? b_we : a_we;
                        address  <= (pick_id == REQ_B) ? b_addr : a_addr;
                        data_in  <= (pick_id == REQ_B) ? b_wdata : a_wdata;
                        write_sw <= (pick_id == REQ_B) ? b_we : a_we;
                        read_sw  <= (pick_id == REQ_B) ? ~b_we : ~a_we;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= WAIT_END;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_END: begin
                    if (endcommand) begin
                        read_sw  <= 1'b0;
                        write_sw <= 1'b0;
                        state    <= RELEASE;
                        if (win_id == REQ_B) begin
                            b_done <= 1'b1;
                            if (!win_we) b_rdata <= data_out;
                        end else begin
                            a_done <= 1'b1;
                            if (!win_we) a_rdata <= data_out;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Watchdog: abandon the command, report an error with done.
                        read_sw  <= 1'b0;
                        write_sw <= 1'b0;
                        state    <= RELEASE;
                        if (win_id == REQ_B) begin
                            b_done <= 1'b1;
                            b_err  <= 1'b1;
                        end else begin
                            a_done <= 1'b1;
                            a_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    last_id <= win_id;
                    cnt     <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    read_sw  <= 1'b0;
                    write_sw <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - directed self-checking bench for psram_arbiter
module tb_psram_arbiter;

    logic        mem_clk = 1'b0;
    logic        rst_n;
    logic        qpi_on;
    logic        a_req, a_we, b_req, b_we;
    logic [23:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        busy, read_sw, write_sw, endcommand;
    logic [23:0] address;
    logic [15:0] data_in, data_out;

    int checks = 0;
    int errors = 0;

    int          cyc = 0, sw_cnt = 0, low_run = 0, gap_min = 1000;
    int          wr_run = 0, wr_run_max = 0, both_hi = 0, sw_hi_cnt = 0;
    int          a_gnt_cnt = 0, gnt_n = 0, gnt_cyc = 0, last_gnt_cyc = 0, period_min = 1000;
    int          a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0, b_done_cyc = 0;
    int          mdl_delay = 0, n0 = 0, nb0 = 0, guard = 0;
    logic        had_txn = 1'b0, wr_seen = 1'b0;
    logic        saw_a_gnt = 1'b0, saw_b_gnt = 1'b0, saw_a_done = 1'b0, saw_b_done = 1'b0;
    logic        a_err_s = 1'b0, b_err_s = 1'b0, sw_at_done = 1'b0;
    logic [15:0] a_rd_s = '0, mdl_key = '0, last_data = '0;
    logic [23:0] last_addr = '0;
    logic [3:0]  gnt_hist = '0;

    always #5 mem_clk = ~mem_clk;

    psram_arbiter #(
        .ADDR_W(24), .DATA_W(16), .HOLD_CYCLES(2), .GAP_CYCLES(4), .TIMEOUT(64)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .qpi_on(qpi_on),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .busy(busy), .address(address), .data_in(data_in),
        .read_sw(read_sw), .write_sw(write_sw),
        .endcommand(endcommand), .data_out(data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update psram model and monitors, return just after posedge.
    task automatic step();
        @(negedge mem_clk);
        cyc++;
        if (read_sw && write_sw) both_hi++;
        if (read_sw || write_sw) begin
            sw_hi_cnt++;
            if (had_txn && low_run > 0 && low_run < gap_min) gap_min = low_run;
            had_txn = 1'b1;
            low_run = 0;
            sw_cnt++;
        end else begin
            low_run++;
            sw_cnt = 0;
        end
        if (write_sw) begin
            wr_seen = 1'b1;
            wr_run++;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
            last_addr = address;
            last_data = data_in;
        end else begin
            wr_run = 0;
        end
        endcommand = (mdl_delay > 0) && (sw_cnt >= mdl_delay);
        data_out   = address[15:0] ^ mdl_key;
        saw_a_gnt  = a_gnt;
        saw_b_gnt  = b_gnt;
        if (a_gnt) a_gnt_cnt++;
        if (a_gnt || b_gnt) begin
            gnt_hist = {gnt_hist[2:0], b_gnt};
            gnt_n++;
            if (gnt_n > 1 && (cyc - last_gnt_cyc) < period_min) period_min = cyc - last_gnt_cyc;
            last_gnt_cyc = cyc;
            gnt_cyc = cyc;
        end
        saw_a_done = a_done;
        saw_b_done = b_done;
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
            a_err_s    = a_err;
            a_rd_s     = a_rdata;
            sw_at_done = read_sw | write_sw;
        end
        if (b_done) begin
            b_done_cnt++;
            b_done_cyc = cyc;
            b_err_s    = b_err;
            sw_at_done = read_sw | write_sw;
        end
        @(posedge mem_clk);
        #1;
    endtask

    task automatic wait_gnt(input logic want_b, input int limit, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(want_b ? saw_b_gnt : saw_a_gnt) && n < limit);
        check(tag, 32'(want_b ? saw_b_gnt : saw_a_gnt), 32'd1);
    endtask

    task automatic wait_done(input logic want_b, input int limit, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(want_b ? saw_b_done : saw_a_done) && n < limit);
        check(tag, 32'(want_b ? saw_b_done : saw_a_done), 32'd1);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; qpi_on = 1'b0; endcommand = 1'b0; data_out = '0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        step();
        check("reset_flags", 32'({a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy, read_sw, write_sw}), 32'd0);
        check("reset_bus", 32'({address, a_rdata, b_rdata, data_in} != 0), 32'd0);
        step();
        rst_n = 1'b1;

        // No grant while qpi_on is low.
        a_we = 1'b1; a_addr = 24'h000123; a_wdata = 16'hBEEF; a_req = 1'b1; mdl_delay = 10;
        repeat (100) step();
        check("no_gnt_qpi_off", 32'(a_gnt_cnt), 32'd0);
        check("no_sw_qpi_off", 32'(sw_hi_cnt), 32'd0);

        // Write: gnt same cycle as qpi_on, endcommand on 10th switch cycle, done next cycle.
        qpi_on = 1'b1;
        wait_gnt(1'b0, 1, "qpi_up_gnt");
        a_req = 1'b0;
        wait_done(1'b0, 40, "wr_done");
        check("wr_hold", 32'(wr_run_max >= 10), 32'd1);
        check("wr_latency", 32'(a_done_cyc - gnt_cyc), 32'd11);
        check("wr_addr", 32'(last_addr), 32'h000123);
        check("wr_data", 32'(last_data), 32'hBEEF);
        check("wr_err", 32'(a_err_s), 32'd0);
        check("wr_sw_low_at_done", 32'(sw_at_done), 32'd0);

        // Read back 0xBEEF from 0x000123.
        a_we = 1'b0; mdl_delay = 3; mdl_key = 16'hBFCC; wr_seen = 1'b0; a_req = 1'b1;
        wait_gnt(1'b0, 20, "rd_gnt");
        a_req = 1'b0;
        wait_done(1'b0, 40, "rd_done");
        check("rd_data_at_done", 32'(a_rd_s), 32'hBEEF);
        check("rd_no_write_sw", 32'(wr_seen), 32'd0);
        check("rd_latency", 32'(a_done_cyc - gnt_cyc), 32'd4);
        check("rd_err", 32'(a_err_s), 32'd0);

        // Both requesting continuously: A was served last, so B, A, B, A.
        check("b_rdata_untouched", 32'(b_rdata), 32'd0);
        mdl_delay = 1; mdl_key = 16'h0000;
        a_addr = 24'h000A5A; b_addr = 24'h0003C3; b_we = 1'b0;
        gnt_n = 0; gnt_hist = '0; period_min = 1000; gap_min = 1000;
        a_req = 1'b1; b_req = 1'b1;
        guard = 0;
        while (gnt_n < 4 && guard < 80) begin
            step();
            guard++;
        end
        a_req = 1'b0; b_req = 1'b0;
        check("rr_count", 32'(gnt_n), 32'd4);
        wait_idle(40, "rr_idle");
        check("rr_order", 32'(gnt_hist), 32'b1010);
        check("rr_period", 32'(period_min), 32'd9);
        check("rr_gap_low", 32'(gap_min), 32'd6);
        check("rr_a_rdata", 32'(a_rdata), 32'h0A5A);
        check("rr_b_rdata", 32'(b_rdata), 32'h03C3);

        // Watchdog: endcommand never comes.
        mdl_delay = 0; a_addr = 24'h000077; a_req = 1'b1;
        wait_gnt(1'b0, 20, "to_gnt");
        a_req = 1'b0;
        wait_done(1'b0, 100, "to_done");
        check("to_err", 32'(a_err_s), 32'd1);
        check("to_latency", 32'(a_done_cyc - gnt_cyc), 32'd67);
        check("to_sw_low", 32'(sw_at_done), 32'd0);
        check("to_rdata_kept", 32'(a_rdata), 32'h0A5A);

        // B write afterwards; endcommand already high during ISSUE must be ignored.
        b_we = 1'b1; b_addr = 24'h000055; b_wdata = 16'h1234; mdl_delay = 2; b_req = 1'b1;
        wait_gnt(1'b1, 20, "b_wr_gnt");
        b_req = 1'b0;
        wait_done(1'b1, 40, "b_wr_done");
        check("b_wr_err", 32'(b_err_s), 32'd0);
        check("b_wr_latency", 32'(b_done_cyc - gnt_cyc), 32'd4);
        check("b_wr_addr", 32'(last_addr), 32'h000055);
        check("b_wr_data", 32'(last_data), 32'h1234);
        check("b_wr_rdata_kept", 32'(b_rdata), 32'h03C3);

        // Reset in the middle of WAIT_END.
        wait_idle(20, "pre_rst_idle");
        mdl_delay = 0; a_we = 1'b0; a_addr = 24'h000099; a_req = 1'b1;
        wait_gnt(1'b0, 20, "rst_gnt");
        a_req = 1'b0;
        repeat (5) step();
        check("rst_pre_read_sw", 32'(read_sw), 32'd1);
        n0 = a_done_cnt; nb0 = b_done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_async_read_sw", 32'(read_sw), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("rst_no_done", 32'(a_done_cnt + b_done_cnt - n0 - nb0), 32'd0);
        check("rst_rdata_clear", 32'(a_rdata), 32'd0);
        rst_n = 1'b1;
        mdl_delay = 1; a_req = 1'b1; b_req = 1'b1;
        wait_gnt(1'b0, 1, "post_rst_a_first");
        check("post_rst_no_b", 32'(saw_b_gnt), 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        wait_done(1'b0, 40, "post_rst_done");
        check("never_both_sw", 32'(both_hi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
